sync_fifo_reader: RTL and testbench

//  Read-side master for the sync FIFO tile's pin interface: watches empty/data, issues rd_en pops,
//  and presents popped words on a valid/ready stream. Credit-based so no popped word is ever lost,
//  and back-pressure from m_ready never causes an over-read. Sits between the FIFO and any consumer.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_reader_buf.sv | 66 ++++++
 rtl/sync_fifo_reader.sv | 122 ++++++++++++
 tb/tb_sync_fifo_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync FIFO read-side master.
// Optional pop counter is enabled with SYNC_FIFO_RD_COUNT_EN (see sync_fifo_reader).
package sync_fifo_pkg;

    localparam int DW_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Width of a counter that must hold 0..buf_dep inclusive.
    function automatic int cnt_width(input int buf_dep);
        return $clog2(buf_dep + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_reader_buf.sv
// Output buffer for sync_fifo_reader: FIFO-ordered shift buffer whose head entry
// is the registered stream word; capture and drain may happen in the same cycle.
module sync_fifo_rd_buf
    import sync_fifo_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int BUF_DEP = 2,
    parameter int CW      = cnt_width(BUF_DEP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          valid,
    output logic [DW-1:0] data,
    input  logic          ready,
    output logic [CW-1:0] occupancy
);

    logic [DW-1:0] mem_q [BUF_DEP];
    logic [DW-1:0] mem_d [BUF_DEP];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          drain;

    assign drain = valid_q & ready;

    // Slots at or above the count are kept at zero, so the head reads 0 when empty.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (drain) begin
            for (int unsigned i = 0; i + 1 < BUF_DEP; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[BUF_DEP-1] = '0;
            cnt_d = cnt_q - CW'(1);
        end
        if (wr_en) begin
            for (int unsigned i = 0; i < BUF_DEP; i++) begin
                if (CW'(i) == cnt_d) begin
                    mem_d[i] = wr_data;
                end
            end
            cnt_d = cnt_d + CW'(1);
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid     = valid_q;
    assign data      = mem_q[0];
    assign occupancy = cnt_q;

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side master for the sync FIFO pin interface: credit-limited pops, tag pipe, stream out.
// Define SYNC_FIFO_RD_COUNT_EN to add the pop_count port and its 8-bit wrap counter.
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int RD_LAT  = 1,
    parameter int BUF_DEP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd_en,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic          busy
`ifdef SYNC_FIFO_RD_COUNT_EN
    ,
    output logic [7:0]    pop_count
`endif
);

    localparam int CW = cnt_width(BUF_DEP);

    rd_state_t         state_q, state_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     occupancy;
    logic [CW:0]       committed;
    logic              tag_out;
    logic              handshake;
    logic              credit_avail;

    assign tag_out   = tag_q[RD_LAT-1];
    assign handshake = m_valid & m_ready;

    // A word leaving this cycle frees its slot for a pop issued in the same cycle.
    assign committed    = {1'b0, inflight_q} + {1'b0, occupancy};
    assign credit_avail = committed < ((CW+1)'(BUF_DEP) + {{CW{1'b0}}, handshake});

    assign fifo_rd_en = (state_q == RUN) & enable & ~fifo_empty & credit_avail;

    always_comb begin
        tag_d    = '0;
        tag_d[0] = fifo_rd_en;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        inflight_d = inflight_q + CW'(fifo_rd_en) - CW'(tag_out);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable && inflight_q != '0) begin
                    state_d = RUN;
                end else if (inflight_q == '0 && occupancy == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo_rd_buf #(
        .DW      (DW),
        .BUF_DEP (BUF_DEP),
        .CW      (CW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (tag_out),
        .wr_data   (fifo_dout),
        .valid     (m_valid),
        .data      (m_data),
        .ready     (m_ready),
        .occupancy (occupancy)
    );

    assign busy = (inflight_q != '0) | (occupancy != '0);

`ifdef SYNC_FIFO_RD_COUNT_EN
    logic [7:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q + 8'(fifo_rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_count_q <= '0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: two instances (RD_LAT=1/BUF_DEP=2 and RD_LAT=3/BUF_DEP=4)
// fed from an index-range FIFO model and checked against a queue of popped words.
module tb_sync_fifo_reader;
    import sync_fifo_pkg::*;

    localparam int DW = 6;
    localparam int NI = 2;
    localparam int LAT [NI] = '{1, 3};
    localparam int DEP [NI] = '{2, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, m_ready, force_empty;
    logic [NI-1:0] rd_en_w, m_valid_w, busy_w, fifo_empty_w;
    logic [DW-1:0] fifo_dout_w [NI];
    logic [DW-1:0] m_data_w [NI];
`ifdef SYNC_FIFO_RD_COUNT_EN
    logic [7:0] pop_count_w [NI];
`endif

    // Upstream FIFO: holds words with indices rd_cnt .. wr_total-1, word(i) = i+1.
    int rd_cnt [NI];
    int wr_total [NI];
    logic [DW-1:0] dline [NI][3];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        assign fifo_empty_w[g] = force_empty | (rd_cnt[g] >= wr_total[g]);
        assign fifo_dout_w[g]  = dline[g][LAT[g]-1];

        sync_fifo_reader #(
            .DW      (DW),
            .RD_LAT  (LAT[g]),
            .BUF_DEP (DEP[g])
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .fifo_empty (fifo_empty_w[g]),
            .fifo_dout  (fifo_dout_w[g]),
            .fifo_rd_en (rd_en_w[g]),
            .m_valid    (m_valid_w[g]),
            .m_data     (m_data_w[g]),
            .m_ready    (m_ready),
            .busy       (busy_w[g])
`ifdef SYNC_FIFO_RD_COUNT_EN
            ,
            .pop_count  (pop_count_w[g])
`endif
        );
    end

    int total, bad, cyc;
    logic [DW-1:0] exp_q [NI][$];
    int consumed [NI], pops [NI], pops_rst [NI];
    int first_pop [NI], first_valid [NI], last_hs [NI], base [NI];

    function automatic logic [DW-1:0] word(input int idx);
        return DW'(idx + 1);
    endfunction

    task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, inst, obs, expv);
        end
    endtask

    task automatic reset_stats();
        for (int g = 0; g < NI; g++) begin
            consumed[g]    = 0;
            pops[g]        = 0;
            first_pop[g]   = -1;
            first_valid[g] = -1;
            last_hs[g]     = -1;
        end
    endtask

    function automatic bit settled();
        for (int g = 0; g < NI; g++) begin
            if (busy_w[g] || exp_q[g].size() != 0 || rd_cnt[g] != wr_total[g]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Observe one cycle mid-period, then let the edge happen and update the FIFO model.
    task automatic tick();
        logic [NI-1:0] pop;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            pop[g] = rd_en_w[g];
            check("rd_en_while_empty", g, 32'(rd_en_w[g] & fifo_empty_w[g]), 32'd0);
            if (rst) begin
                exp_q[g].delete();
                pops_rst[g] = 0;
            end else begin
                check("busy", g, 32'(busy_w[g]), 32'(exp_q[g].size() != 0));
`ifdef SYNC_FIFO_RD_COUNT_EN
                check("pop_count", g, 32'(pop_count_w[g]), 32'(pops_rst[g] % 256));
`endif
                if (m_valid_w[g] && first_valid[g] < 0) first_valid[g] = cyc;
                if (m_valid_w[g] && m_ready) begin
                    if (exp_q[g].size() == 0) begin
                        check("spurious_word_depth", g, 32'(exp_q[g].size()), 32'd1);
                    end else begin
                        check("m_data", g, 32'(m_data_w[g]), 32'(exp_q[g].pop_front()));
                        consumed[g]++;
                        last_hs[g] = cyc;
                    end
                end
                if (pop[g]) begin
                    exp_q[g].push_back(word(rd_cnt[g]));
                    pops[g]++;
                    pops_rst[g]++;
                    if (first_pop[g] < 0) first_pop[g] = cyc;
                end
                check("credit", g, 32'(exp_q[g].size() <= DEP[g]), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < NI; g++) begin
            for (int k = 2; k > 0; k--) dline[g][k] = dline[g][k-1];
            dline[g][0] = pop[g] ? word(rd_cnt[g]) : DW'($urandom);
            if (pop[g]) rd_cnt[g]++;
        end
    endtask

    task automatic drain_wait(input int limit);
        for (int k = 0; k < limit && !settled(); k++) tick();
        check("drain_timeout", 0, 32'(settled()), 32'd1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
        for (int g = 0; g < NI; g++) begin
            rd_cnt[g] = 0;
            wr_total[g] = 16;
            pops_rst[g] = 0;
            for (int k = 0; k < 3; k++) dline[g][k] = '0;
        end
        reset_stats();

        // 1: reset with a non-empty FIFO
        tick();
        tick();
        for (int g = 0; g < NI; g++) begin
            check("rst_rd_en", g, 32'(rd_en_w[g]), 32'd0);
            check("rst_m_valid", g, 32'(m_valid_w[g]), 32'd0);
            check("rst_m_data", g, 32'(m_data_w[g]), 32'd0);
            check("rst_busy", g, 32'(busy_w[g]), 32'd0);
`ifdef SYNC_FIFO_RD_COUNT_EN
            check("rst_pop_count", g, 32'(pop_count_w[g]), 32'd0);
`endif
        end
        rst = 1'b0;

        // 2: streaming 0x01..0x10
        reset_stats();
        enable = 1'b1;
        m_ready = 1'b1;
        drain_wait(80);
        for (int g = 0; g < NI; g++) begin
            check("stream_count", g, 32'(consumed[g]), 32'd16);
            check("latency", g, 32'(first_valid[g] - first_pop[g]), 32'(LAT[g] + 1));
            check("throughput", g, 32'(last_hs[g] - first_valid[g]), 32'd15);
        end

        // 3: back-pressure with 8 words waiting
        reset_stats();
        m_ready = 1'b0;
        for (int g = 0; g < NI; g++) begin
            base[g] = rd_cnt[g];
            wr_total[g] += 8;
        end
        repeat (10) tick();
        for (int g = 0; g < NI; g++) begin
            check("stall_pops", g, 32'(pops[g]), 32'(DEP[g]));
            check("stall_valid", g, 32'(m_valid_w[g]), 32'd1);
            check("stall_data", g, 32'(m_data_w[g]), 32'(word(base[g])));
        end
        m_ready = 1'b1;
        drain_wait(60);
        for (int g = 0; g < NI; g++) check("bp_count", g, 32'(consumed[g]), 32'd8);

        // 4: fifo_empty toggling every 3 cycles, random ready
        reset_stats();
        for (int g = 0; g < NI; g++) wr_total[g] += 20;
        for (int k = 0; k < 90; k++) begin
            force_empty = 1'((k / 3) % 2);
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        force_empty = 1'b0;
        m_ready = 1'b1;
        drain_wait(80);
        for (int g = 0; g < NI; g++) check("empty_tog_count", g, 32'(consumed[g]), 32'd20);

        // 5: disable with one pop in flight
        reset_stats();
        for (int g = 0; g < NI; g++) wr_total[g] += 8;
        tick();
        for (int g = 0; g < NI; g++) check("dis_first_pop", g, 32'(pops[g]), 32'd1);
        enable = 1'b0;
        reset_stats();
        repeat (12) tick();
        for (int g = 0; g < NI; g++) begin
            check("dis_no_pops", g, 32'(pops[g]), 32'd0);
            check("dis_delivered", g, 32'(consumed[g]), 32'd1);
            check("dis_busy", g, 32'(busy_w[g]), 32'd0);
        end

        // 6: reset during a full-buffer stall, then counter wrap
        reset_stats();
        enable = 1'b1;
        m_ready = 1'b0;
        for (int g = 0; g < NI; g++) wr_total[g] += 8;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            check("mid_rst_m_valid", g, 32'(m_valid_w[g]), 32'd0);
            check("mid_rst_m_data", g, 32'(m_data_w[g]), 32'd0);
            check("mid_rst_busy", g, 32'(busy_w[g]), 32'd0);
`ifdef SYNC_FIFO_RD_COUNT_EN
            check("mid_rst_pop_count", g, 32'(pop_count_w[g]), 32'd0);
`endif
        end
        reset_stats();
        m_ready = 1'b1;
        drain_wait(60);
        for (int g = 0; g < NI; g++) check("post_rst_count", g, 32'(consumed[g]), 32'(15 - DEP[g]));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_stats();
        for (int g = 0; g < NI; g++) wr_total[g] += 257;
        drain_wait(400);
        for (int g = 0; g < NI; g++) begin
            check("wrap_count", g, 32'(consumed[g]), 32'd257);
`ifdef SYNC_FIFO_RD_COUNT_EN
            check("wrap_pop_count", g, 32'(pop_count_w[g]), 32'd1);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
